// File: rtl/recirc_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : recirc_link_ctrl
//  Purpose  : Link sequencer for the recirculation stage. Watches the lane
//             word stream, declares the link active after a run of training
//             words, and drops it after a run of idle cycles or on an
//             upper-layer request. The registered 'active' output selects
//             forward (1, to demux_0) or loop-back (0, recirculate).
//
//  Ports    : clk_2f      in   sole clock, rising edge
//             reset       in   synchronous, active-high reset
//             data_input  in   [DATA_WIDTH-1:0] lane word
//             valid       in   data_input qualifier
//             force_idle  in   level request to drop / hold the link down
//             active      out  registered recirculator select
//             state       out  [1:0] 0 RESET, 1 SEARCH, 2 ACTIVE, 3 HOLD
//             link_up     out  one-cycle pulse on first active=1 cycle
//             link_down   out  one-cycle pulse on first active=0 after ACTIVE
//             stat_fwd    out  [15:0] forwarded-word counter
//             stat_recirc out  [15:0] recirculated-word counter
//
//  Options  : RECIRC_LINK_CTRL_STATS_EN - when defined, stat_fwd/stat_recirc
//             are saturating 16-bit counters; otherwise both read 16'h0000.
//
//  Revision : 1.0 - initial release
// ============================================================================
module recirc_link_ctrl #(
   parameter int                    DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 32'hBCBC_BCBC,
   parameter int                    TRAIN_COUNT   = 4,
   parameter int                    LOSS_COUNT    = 4
) (
   input  logic                  clk_2f,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_input,
   input  logic                  valid,
   input  logic                  force_idle,
   output logic                  active,
   output logic [1:0]            state,
   output logic                  link_up,
   output logic                  link_down,
   output logic [15:0]           stat_fwd,
   output logic [15:0]           stat_recirc
);

   // FSM encoding is externally visible on the 'state' port.
   localparam logic [1:0] c_ST_RESET  = 2'd0;
   localparam logic [1:0] c_ST_SEARCH = 2'd1;
   localparam logic [1:0] c_ST_ACTIVE = 2'd2;
   localparam logic [1:0] c_ST_HOLD   = 2'd3;

   localparam logic [7:0] c_TRAIN_TGT = 8'(TRAIN_COUNT);
   localparam logic [7:0] c_LOSS_TGT  = 8'(LOSS_COUNT);
   localparam logic [7:0] c_CNT_MAX   = 8'hFF;

   // ------------------------------------------------------------------------
   // State and counters
   // ------------------------------------------------------------------------
   logic [1:0] r_state;
   logic [7:0] r_train_cnt;
   logic [7:0] r_loss_cnt;
   logic       r_active;
   logic       r_link_up;
   logic       r_link_down;

   logic [1:0] w_state_nxt;
   logic [7:0] w_train_nxt;
   logic [7:0] w_loss_nxt;
   logic [7:0] w_train_inc;
   logic [7:0] w_loss_inc;
   logic       w_is_pattern;
   logic       w_active_nxt;
   logic       w_link_up_nxt;
   logic       w_link_down_nxt;

   assign w_is_pattern = (data_input == TRAIN_PATTERN);

   // Saturating increments; the compare below uses the incremented value so
   // the transition happens on the edge that samples the N-th event.
   assign w_train_inc = (r_train_cnt == c_CNT_MAX) ? c_CNT_MAX : r_train_cnt + 8'd1;
   assign w_loss_inc  = (r_loss_cnt  == c_CNT_MAX) ? c_CNT_MAX : r_loss_cnt  + 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_train_nxt = r_train_cnt;
      w_loss_nxt  = r_loss_cnt;

      case (r_state)
         c_ST_RESET: begin
            w_state_nxt = c_ST_SEARCH;
            w_train_nxt = 8'd0;
            w_loss_nxt  = 8'd0;
         end

         c_ST_SEARCH: begin
            w_loss_nxt = 8'd0;
            if (force_idle) begin
               // Upper layer wins over a qualifying word on the same edge.
               w_train_nxt = 8'd0;
            end else if (valid) begin
               if (w_is_pattern) begin
                  if (w_train_inc >= c_TRAIN_TGT) begin
                     w_state_nxt = c_ST_ACTIVE;
                     w_train_nxt = 8'd0;
                  end else begin
                     w_train_nxt = w_train_inc;
                  end
               end else begin
                  w_train_nxt = 8'd0;
               end
            end
            // valid=0: a gap neither breaks nor advances the run.
         end

         c_ST_ACTIVE: begin
            // Pattern words are plain payload once the link is up.
            w_train_nxt = 8'd0;
            if (force_idle) begin
               w_state_nxt = c_ST_HOLD;
               w_loss_nxt  = 8'd0;
            end else if (valid) begin
               w_loss_nxt = 8'd0;
            end else if (w_loss_inc >= c_LOSS_TGT) begin
               w_state_nxt = c_ST_HOLD;
               w_loss_nxt  = 8'd0;
            end else begin
               w_loss_nxt = w_loss_inc;
            end
         end

         c_ST_HOLD: begin
            // Words seen here never count toward training.
            w_train_nxt = 8'd0;
            w_loss_nxt  = 8'd0;
            if (!force_idle) begin
               w_state_nxt = c_ST_SEARCH;
            end
         end

         default: begin
            w_state_nxt = c_ST_RESET;
            w_train_nxt = 8'd0;
            w_loss_nxt  = 8'd0;
         end
      endcase
   end

   // Outputs derive from the transition so they register alongside the state;
   // SEARCH->ACTIVE and ACTIVE->HOLD are mutually exclusive, so the pulses
   // can never coincide and each lasts exactly one cycle.
   assign w_active_nxt    = (w_state_nxt == c_ST_ACTIVE);
   assign w_link_up_nxt   = (r_state == c_ST_SEARCH) && (w_state_nxt == c_ST_ACTIVE);
   assign w_link_down_nxt = (r_state == c_ST_ACTIVE) && (w_state_nxt == c_ST_HOLD);

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         // Reset mid-ACTIVE drops the select silently: no link_down pulse.
         r_state     <= c_ST_RESET;
         r_train_cnt <= 8'd0;
         r_loss_cnt  <= 8'd0;
         r_active    <= 1'b0;
         r_link_up   <= 1'b0;
         r_link_down <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_train_cnt <= w_train_nxt;
         r_loss_cnt  <= w_loss_nxt;
         r_active    <= w_active_nxt;
         r_link_up   <= w_link_up_nxt;
         r_link_down <= w_link_down_nxt;
      end
   end

   assign active    = r_active;
   assign state     = r_state;
   assign link_up   = r_link_up;
   assign link_down = r_link_down;

   // ------------------------------------------------------------------------
   // Traffic statistics
   // ------------------------------------------------------------------------
`ifdef RECIRC_LINK_CTRL_STATS_EN
   logic [15:0] r_stat_fwd;
   logic [15:0] r_stat_recirc;
   logic        w_fwd_hit;
   logic        w_recirc_hit;

   // Classification uses the registered select of the same cycle, i.e. the
   // path the word actually took through the recirculator.
   assign w_fwd_hit    = valid &&  r_active;
   assign w_recirc_hit = valid && !r_active && (r_state != c_ST_RESET);

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         r_stat_fwd    <= 16'h0000;
         r_stat_recirc <= 16'h0000;
      end else begin
         if (w_fwd_hit && (r_stat_fwd != 16'hFFFF)) begin
            r_stat_fwd <= r_stat_fwd + 16'd1;
         end
         if (w_recirc_hit && (r_stat_recirc != 16'hFFFF)) begin
            r_stat_recirc <= r_stat_recirc + 16'd1;
         end
      end
   end

   assign stat_fwd    = r_stat_fwd;
   assign stat_recirc = r_stat_recirc;
`else
   assign stat_fwd    = 16'h0000;
   assign stat_recirc = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_recirc_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_recirc_link_ctrl
//  Purpose  : Directed self-checking bench for recirc_link_ctrl. Inputs are
//             driven 1 ns after each rising edge; outputs are sampled at the
//             same point, i.e. after the edge that consumed the prior inputs.
//  Options  : RECIRC_LINK_CTRL_STATS_EN selects the expected counter values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_recirc_link_ctrl;

   localparam logic [31:0] c_PAT = 32'hBCBC_BCBC;

`ifdef RECIRC_LINK_CTRL_STATS_EN
   localparam logic [31:0] c_EXP_FWD    = 32'd20;
   localparam logic [31:0] c_EXP_RECIRC = 32'd10;
`else
   localparam logic [31:0] c_EXP_FWD    = 32'd0;
   localparam logic [31:0] c_EXP_RECIRC = 32'd0;
`endif

   logic        clk_2f = 1'b0;
   logic        reset;
   logic [31:0] data_input;
   logic        valid;
   logic        force_idle;
   logic        active;
   logic [1:0]  state;
   logic        link_up;
   logic        link_down;
   logic [15:0] stat_fwd;
   logic [15:0] stat_recirc;

   int n_assert = 0;
   int n_fail   = 0;

   recirc_link_ctrl u_dut (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .data_input  (data_input),
      .valid       (valid),
      .force_idle  (force_idle),
      .active      (active),
      .state       (state),
      .link_up     (link_up),
      .link_down   (link_down),
      .stat_fwd    (stat_fwd),
      .stat_recirc (stat_recirc)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic tick();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic f);
      valid      = v;
      data_input = d;
      force_idle = f;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full output snapshot: state, active, link_up, link_down.
   task automatic check_all(input string tag, input logic [1:0] st, input logic act,
                            input logic up, input logic dn);
      check({tag, ".state"},     32'(state),     32'(st));
      check({tag, ".active"},    32'(active),    32'(act));
      check({tag, ".link_up"},   32'(link_up),   32'(up));
      check({tag, ".link_down"}, 32'(link_down), 32'(dn));
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      check_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
      check("reset.stat_fwd",    32'(stat_fwd),    32'd0);
      check("reset.stat_recirc", 32'(stat_recirc), 32'd0);

      reset = 1'b0;
      tick();
      check_all("rst_release", 2'd1, 1'b0, 1'b0, 1'b0);

      // ---- 6 non-pattern words then 4 patterns (all recirculated) ----
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
         tick();
      end
      check_all("pre_train", 2'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, c_PAT, 1'b0);
         tick();
         if (i == 2) check_all("train3", 2'd1, 1'b0, 1'b0, 1'b0);
      end
      check_all("train4_up", 2'd2, 1'b1, 1'b1, 1'b0);

      // ---- 20 forwarded words, patterns among them are plain data ----
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, (i % 2 == 0) ? c_PAT : 32'(i), 1'b0);
         tick();
         if (i == 0) check_all("fwd_first", 2'd2, 1'b1, 1'b0, 1'b0);
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      check("stats.stat_fwd",    32'(stat_fwd),    c_EXP_FWD);
      check("stats.stat_recirc", 32'(stat_recirc), c_EXP_RECIRC);

      // ---- loss: 3 idle, 1 valid, 4 idle ----
      drive(1'b1, 32'hAAAA_5555, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check_all("gap3", 2'd2, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h1234_5678, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check_all("loss3", 2'd2, 1'b1, 1'b0, 1'b0);
      tick();
      check_all("loss4_down", 2'd3, 1'b0, 1'b0, 1'b1);
      tick();
      check_all("hold_exit", 2'd1, 1'b0, 1'b0, 1'b0);

      // ---- broken run: P P X then P P gap P P ----
      drive(1'b1, c_PAT, 1'b0);
      tick();
      tick();
      check_all("pair", 2'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h1234_5678, 1'b0);
      tick();
      drive(1'b1, c_PAT, 1'b0);
      tick();
      tick();
      drive(1'b0, c_PAT, 1'b0);
      tick();
      check_all("run2_gap", 2'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, c_PAT, 1'b0);
      tick();
      check_all("run3", 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("run4_up", 2'd2, 1'b1, 1'b1, 1'b0);

      // ---- force_idle for 5 cycles while patterns stream ----
      drive(1'b1, c_PAT, 1'b1);
      tick();
      check_all("force1", 2'd3, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      check_all("force5", 2'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b1, c_PAT, 1'b0);
      tick();
      check_all("release", 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      check_all("retrain3", 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("retrain4_up", 2'd2, 1'b1, 1'b1, 1'b0);

      // ---- reset mid-ACTIVE ----
      reset = 1'b1;
      tick();
      check_all("mid_reset", 2'd0, 1'b0, 1'b0, 1'b0);
      check("mid_reset.stat_fwd",    32'(stat_fwd),    32'd0);
      check("mid_reset.stat_recirc", 32'(stat_recirc), 32'd0);
      reset = 1'b0;
      tick();
      check_all("mid_reset_rel", 2'd1, 1'b0, 1'b0, 1'b0);

      // ---- force_idle beats a qualifying 4th pattern in SEARCH ----
      drive(1'b1, c_PAT, 1'b0);
      tick();
      tick();
      tick();
      drive(1'b1, c_PAT, 1'b1);
      tick();
      check_all("search_force", 2'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, c_PAT, 1'b0);
      tick();
      tick();
      tick();
      check_all("after_force3", 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("after_force4_up", 2'd2, 1'b1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/recirc_link_ctrl.md
Name: recirc_link_ctrl

Overview:
- Sequencer that drives the `active` select of the recirculation stage.
- Watches the 32-bit lane word stream on clk_2f and declares the link active after a run of training-pattern words.
- Drops `active` after a run of idle (invalid) cycles, or on request from the upper layer.
- While `active` is low, the recirculator loops data back to the test side; while high, it forwards data to demux_0.

Parameters:
- DATA_WIDTH, 32, lane word width.
- TRAIN_PATTERN, 32'hBCBC_BCBC, training/COM word that qualifies link-up.
- TRAIN_COUNT, 4, consecutive valid pattern words needed for link-up; legal range 1..255.
- LOSS_COUNT, 4, consecutive cycles with valid=0 that cause link-down; legal range 1..255.

Ports:
- clk_2f  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_input  input  DATA_WIDTH  lane word, same word the recirculator receives.
- valid  input  1  data_input qualifier.
- force_idle  input  1  upper-layer request to drop the link; level-sensitive.
- active  output  1  registered select to the recirculator: 1 = forward to demux_0, 0 = recirculate.
- state  output  2  current FSM state: 0 RESET, 1 SEARCH, 2 ACTIVE, 3 HOLD.
- link_up  output  1  one-cycle pulse, coincident with the first cycle active=1.
- link_down  output  1  one-cycle pulse, coincident with the first cycle active=0 after ACTIVE.
- stat_fwd  output  16  forwarded-word counter (optional feature).
- stat_recirc  output  16  recirculated-word counter (optional feature).

Behaviour:
- Reset: sampled at posedge clk_2f when reset=1.
  - Values while reset: state=RESET, active=0, link_up=0, link_down=0, train_cnt=0, loss_cnt=0, stats=0.
  - Reset mid-ACTIVE: active=0 on the next edge, with no link_down pulse.
- RESET -> SEARCH unconditionally one cycle after reset deasserts.
- SEARCH:
  - valid=1 and data_input==TRAIN_PATTERN: train_cnt increments, saturating at 255.
  - Any other word with valid=1: train_cnt clears.
  - valid=0: train_cnt holds. Gaps neither break nor advance a run.
  - When the edge samples the TRAIN_COUNT-th consecutive pattern word: next state ACTIVE. active=1 and link_up=1 from that edge. Latency is one cycle after the qualifying word is presented.
  - force_idle=1 in SEARCH: train_cnt clears and the FSM stays in SEARCH. force_idle takes priority over a qualifying word on the same edge.
- ACTIVE:
  - active=1.
  - valid=1: loss_cnt clears. Pattern words are ordinary data here and are not counted.
  - valid=0: loss_cnt increments.
  - On the edge that samples the LOSS_COUNT-th consecutive invalid cycle: next state HOLD, active=0, link_down=1.
  - force_idle=1: next state HOLD on that edge, active=0, link_down=1. Takes priority over loss counting.
- HOLD:
  - active=0.
  - train_cnt and loss_cnt cleared.
  - Stays in HOLD while force_idle=1; next edge with force_idle=0 goes to SEARCH.
  - Words arriving during HOLD are not counted toward training.
- Pulses: link_up and link_down are never asserted together and are each exactly one cycle wide.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: RECIRC_LINK_CTRL_STATS_EN.
- Defined:
  - stat_fwd counts cycles with valid=1 and active=1.
  - stat_recirc counts cycles with valid=1 and active=0, excluding the RESET state.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared only by reset.
  - Counting uses the registered active value of the same cycle.
- Undefined: stat_fwd and stat_recirc are tied to 16'h0000 and no counter logic is synthesised. Ports remain present so the bench is unchanged.

Test Plan:
- Reset, then 4 valid words of 32'hBCBCBCBC back-to-back -> active=1 and link_up pulse on the edge after the 4th word; state=2.
- Pattern, pattern, 32'h12345678 (valid), then 4 patterns -> no link-up after the first pair; active rises only after the final 4th pattern (7 words total).
- ACTIVE, then valid=0 for 3 cycles, 1 valid word, then valid=0 for 4 cycles -> active stays 1 through the first gap; drops with a link_down pulse after the 4th invalid cycle; state=3, then 1.
- ACTIVE, force_idle=1 for 5 cycles while valid patterns stream -> active=0 next edge; state=3 for 5 cycles; SEARCH after release; re-trains only after 4 new patterns.
- Reset asserted mid-ACTIVE for 1 cycle -> active=0, no link_down, state 0 then 1; stats read 0.
- With RECIRC_LINK_CTRL_STATS_EN: 10 valid words pre-link (including the 4 patterns), then 20 valid words while active -> stat_recirc=10, stat_fwd=20. Without the macro -> both read 0.
